// File: rtl/tdm_demux7.sv
// tdm_demux7: receive-side TDM demultiplexer.
// Collects NCH consecutive W-bit slots framed by a sync marker on slot 0
// into shadow registers, then publishes the whole frame on o at once.
// Missing or early sync markers raise a one-cycle err pulse; a missing
// sync drops lock (HUNT), an early sync restarts the frame at slot 0.
module tdm_demux7 #(
  parameter int W   = 1,
  parameter int NCH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     i,
  input  logic             sync,
  input  logic             en,
  output logic [NCH*W-1:0] o,
  output logic [2:0]       s,
  output logic             valid,
  output logic             err
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slot index of the final slot; it bypasses the shadow and goes straight to o.
  localparam logic [2:0] LAST_SLOT = 3'(NCH - 1);

  state_t               state_r, state_s;
  logic [2:0]           slot_r, slot_s;
  logic [W-1:0]         shadow_r [NCH-1];
  logic [W-1:0]         shadow_s [NCH-1];
  logic [NCH*W-1:0]     o_r, o_s;
  logic                 valid_r, valid_s;
  logic                 err_r, err_s;

  // Next-state, shadow capture, frame publish and pulse generation.
  always_comb begin
    state_s  = state_r;
    slot_s   = slot_r;
    shadow_s = shadow_r;
    o_s      = o_r;
    valid_s  = 1'b0;
    err_s    = 1'b0;
    if (en) begin
      case (state_r)
        HUNT: begin
          if (sync) begin
            shadow_s[0] = i;
            slot_s      = 3'd1;
            state_s     = RUN;
          end else begin
            slot_s      = 3'd0;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync anywhere but slot 0 is an early sync: the partial
            // frame is abandoned and this sample becomes the new slot 0.
            err_s       = (slot_r != 3'd0);
            shadow_s[0] = i;
            slot_s      = 3'd1;
          end else if (slot_r == 3'd0) begin
            // Slot 0 without its marker: lock is lost, sample dropped.
            err_s   = 1'b1;
            slot_s  = 3'd0;
            state_s = HUNT;
          end else if (slot_r == LAST_SLOT) begin
            for (int k = 0; k < NCH - 1; k++) begin
              o_s[k*W +: W] = shadow_r[k];
            end
            o_s[(NCH-1)*W +: W] = i;
            valid_s = 1'b1;
            slot_s  = 3'd0;
          end else begin
            for (int k = 1; k < NCH - 1; k++) begin
              if (slot_r == 3'(k)) begin
                shadow_s[k] = i;
              end else begin
                shadow_s[k] = shadow_r[k];
              end
            end
            slot_s = slot_r + 3'd1;
          end
        end
        default: begin
          state_s = HUNT;
          slot_s  = 3'd0;
        end
      endcase
    end else begin
      // No slot strobe: everything holds, pulses stay low.
      valid_s = 1'b0;
      err_s   = 1'b0;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
      slot_r  <= 3'd0;
      for (int k = 0; k < NCH - 1; k++) begin
        shadow_r[k] <= '0;
      end
      o_r     <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      for (int k = 0; k < NCH - 1; k++) begin
        shadow_r[k] <= shadow_s[k];
      end
      o_r     <= o_s;
      valid_r <= valid_s;
      err_r   <= err_s;
    end
  end

  assign o     = o_r;
  assign s     = slot_r;
  assign valid = valid_r;
  assign err   = err_r;

endmodule

// File: tb/tb_tdm_demux7.sv
// Testbench for tdm_demux7: directed framing scenarios followed by random
// traffic, checked by a frame-level reference model and a scoreboard.
module tb_tdm_demux7;
  localparam int W   = 1;
  localparam int NCH = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     i = '0;
  logic             sync = 1'b0;
  logic             en = 1'b0;
  logic [NCH*W-1:0] o;
  logic [2:0]       s;
  logic             valid;
  logic             err;

  tdm_demux7 #(.W(W), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .i(i), .sync(sync), .en(en),
    .o(o), .s(s), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       s;
    logic [NCH*W-1:0] o;
    logic             v;
    logic             e;
  } exp_t;

  exp_t             st_q[$];
  logic [NCH*W-1:0] ev_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: frame-level view (lock flag + list of collected samples).
  bit               locked = 1'b0;
  logic [W-1:0]     coll[$];
  logic [NCH*W-1:0] m_o = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and push the predicted post-edge outputs.
  task automatic step(input logic r, input logic e, input logic sy, input logic [W-1:0] d);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sync = sy; i = d;
    x.v = 1'b0;
    x.e = 1'b0;
    if (r) begin
      locked = 1'b0;
      coll.delete();
      m_o = '0;
    end else if (e) begin
      if (!locked) begin
        if (sy) begin
          coll.delete();
          coll.push_back(d);
          locked = 1'b1;
        end
      end else if (sy) begin
        if (coll.size() != 0) x.e = 1'b1;
        coll.delete();
        coll.push_back(d);
      end else if (coll.size() == 0) begin
        x.e = 1'b1;
        locked = 1'b0;
      end else begin
        coll.push_back(d);
        if (coll.size() == NCH) begin
          for (int k = 0; k < NCH; k++) m_o[k*W +: W] = coll[k];
          x.v = 1'b1;
          ev_q.push_back(m_o);
          coll.delete();
        end
      end
    end
    x.s = 3'(coll.size());
    x.o = m_o;
    st_q.push_back(x);
  endtask

  task automatic frame(input logic [NCH-1:0] bits);
    for (int k = 0; k < NCH; k++) step(1'b0, 1'b1, (k == 0), bits[k]);
  endtask

  // Monitor: compare per-cycle expectations and pop the frame scoreboard on valid.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (st_q.size() != 0) begin
      x = st_q.pop_front();
      chk("s", 64'(s), 64'(x.s));
      chk("o", 64'(o), 64'(x.o));
      chk("valid", 64'(valid), 64'(x.v));
      chk("err", 64'(err), 64'(x.e));
      chk("valid_err_excl", 64'(valid & err), 64'd0);
      if (valid) begin
        if (ev_q.size() == 0) begin
          chk("frame_unexpected", 64'(valid), 64'd0);
        end else begin
          chk("frame_data", 64'(o), 64'(ev_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic sy;
    logic e;
    // Reset
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // Frame i=1,0,1,1,0,0,1 -> o=7'b1001101
    frame(7'b1001101);
    @(posedge clk); #2;
    chk("tp_frame1", 64'(o), 64'h4d);
    // Back-to-back second frame i=0,1,0,1,0,1,0 -> o=7'b0101010
    frame(7'b0101010);
    @(posedge clk); #2;
    chk("tp_frame2", 64'(o), 64'h2a);

    // en toggling inside a frame
    for (int k = 0; k < NCH; k++) begin
      step(1'b0, 1'b1, (k == 0), 1'((k * 3) % 2));
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Early sync at s=3, then the restarted frame completes
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, (k == 0), 1'b1);
    frame(7'b0110011);

    // Missing sync, ignored samples, relock
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frame(7'b1110001);

    // Reset at s=4, then a full frame
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, (k == 0), 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    frame(7'b1010110);

    // Random traffic with occasional framing faults and resets
    for (int n = 0; n < 4000; n++) begin
      e  = ($urandom_range(0, 3) != 0);
      sy = (coll.size() == 0) ^ ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 299) == 0), e, sy, W'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #2;
    chk("st_q_drained", 64'(st_q.size()), 64'd0);
    chk("ev_q_drained", 64'(ev_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
